depacketizer_n: RTL and testbench

- Successor to the fixed two-flit combinational depacketizer.
- Receives a packet serially, one flit per handshake, from a NoC router output port. Packets have a parametrised number of flits.
- Strips per-flit control and assembles the payload bits MSB-first into one data word. Captures the packet VC.
- Presents the result on a registered valid/ready output. Flags malformed flit sequences.

---
 rtl/depacketizer_n.sv | 234 +++++++++++++++++++++++
 tb/tb_depacketizer_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/depacketizer_n.sv
// -----------------------------------------------------------------------------
// depacketizer_n
//
// Receives a packet one flit per handshake from a NoC router output port,
// strips the per-flit control fields and assembles the payload MSB-first into
// a single data word. The VC of the packet's head flit travels with the word.
// The assembled word is presented on a registered valid/ready output.
// Malformed flit sequences produce a one-cycle o_error pulse.
//
// Flit layout, MSB down:
//   [W-1] flit valid, [W-2] head, [W-3] tail, then VC,
//   then (head only) destination address, remainder is payload.
//
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   i_flit_in    incoming flit
//   i_valid_in   incoming flit valid
//   i_ready_out  block can accept a flit this cycle
//   o_data_out   assembled payload (top WIDTH_DATA bits of the assembly)
//   o_vc_out     VC of the emitted packet
//   o_valid_out  output word valid
//   o_ready_in   downstream ready
//   o_error      one-cycle pulse on a protocol violation
// -----------------------------------------------------------------------------
module depacketizer_n #(
    parameter int WIDTH_FLIT       = 18,
    parameter int NUM_FLITS        = 2,
    parameter int VC_ADDRESS_WIDTH = 1,
    parameter int ADDRESS_WIDTH    = 4,
    parameter int WIDTH_DATA       = 12
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [WIDTH_FLIT-1:0]       i_flit_in,
    input  logic                        i_valid_in,
    output logic                        i_ready_out,
    output logic [WIDTH_DATA-1:0]       o_data_out,
    output logic [VC_ADDRESS_WIDTH-1:0] o_vc_out,
    output logic                        o_valid_out,
    input  logic                        o_ready_in,
    output logic                        o_error
);

    // Payload widths of head and body/tail flits, and of the full assembly.
    localparam int HD    = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH - ADDRESS_WIDTH;
    localparam int BD    = WIDTH_FLIT - 3 - VC_ADDRESS_WIDTH;
    localparam int IDL   = HD + (NUM_FLITS - 1) * BD;
    localparam int CNT_W = $clog2(NUM_FLITS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_FLITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    // Head payload occupies the top HD bits of the assembly; everything
    // below is cleared so an early tail leaves a zero-filled remainder.
    function automatic logic [IDL-1:0] f_head_slot(input logic [HD-1:0] d);
        logic [IDL-1:0] ext;
        ext = IDL'(d);
        return ext << (IDL - HD);
    endfunction

    // The k-th flit after the head lands directly below the previous one.
    function automatic logic [IDL-1:0] f_body_slot(input logic [BD-1:0] d,
                                                   input logic [CNT_W-1:0] k);
        logic [IDL-1:0] ext;
        int             sh;
        ext = IDL'(d);
        sh  = IDL - HD - BD * int'(k);
        return ext << sh;
    endfunction

    // Registers
    state_t                      r_state;
    logic [IDL-1:0]              r_buf;
    logic [CNT_W-1:0]            r_cnt;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc;
    logic                        r_valid;
    logic [WIDTH_DATA-1:0]       r_data;
    logic [VC_ADDRESS_WIDTH-1:0] r_vc_out;
    logic                        r_err;

    // Flit field decode
    logic                        w_fv;
    logic                        w_head;
    logic                        w_tail;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc;
    logic [HD-1:0]               w_head_data;
    logic [BD-1:0]               w_body_data;
    logic                        w_ready;
    logic                        w_take;

    // Next-state signals
    state_t                      w_state_next;
    logic [IDL-1:0]              w_buf_next;
    logic [CNT_W-1:0]            w_cnt_next;
    logic [VC_ADDRESS_WIDTH-1:0] w_vc_next;
    logic                        w_emit;
    logic                        w_err;

    assign w_fv        = i_flit_in[WIDTH_FLIT-1];
    assign w_head      = i_flit_in[WIDTH_FLIT-2];
    assign w_tail      = i_flit_in[WIDTH_FLIT-3];
    assign w_vc        = i_flit_in[WIDTH_FLIT-4 -: VC_ADDRESS_WIDTH];
    assign w_head_data = i_flit_in[HD-1:0];
    assign w_body_data = i_flit_in[BD-1:0];

    // A new flit can be taken whenever the output register is free or is
    // being drained this cycle, so an emit never overwrites a held word.
    assign w_ready = ~r_valid | o_ready_in;

    // Flits whose own valid bit is clear are consumed but ignored.
    assign w_take = i_valid_in & w_ready & w_fv;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and assembly logic
    always_comb begin
        w_state_next = r_state;
        w_buf_next   = r_buf;
        w_cnt_next   = r_cnt;
        w_vc_next    = r_vc;
        w_emit       = 1'b0;
        w_err        = 1'b0;

        if (w_take) begin
            case (r_state)
                S_IDLE: begin
                    if (w_head) begin
                        w_buf_next = f_head_slot(w_head_data);
                        w_vc_next  = w_vc;
                        w_cnt_next = CNT_ONE;
                        if (w_tail || (NUM_FLITS == 1)) begin
                            w_emit       = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next = S_COLLECT;
                        end
                    end else begin
                        // Orphan body/tail flit: dropped.
                        w_err = 1'b1;
                    end
                end

                S_COLLECT: begin
                    if (w_head) begin
                        // A new head abandons the partial packet and starts
                        // a fresh assembly in the same cycle.
                        w_err      = 1'b1;
                        w_buf_next = f_head_slot(w_head_data);
                        w_vc_next  = w_vc;
                        w_cnt_next = CNT_ONE;
                        if (w_tail) begin
                            w_emit       = 1'b1;
                            w_cnt_next   = '0;
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next = S_COLLECT;
                        end
                    end else begin
                        w_buf_next = r_buf | f_body_slot(w_body_data, r_cnt);
                        w_cnt_next = r_cnt + CNT_ONE;
                        if (w_tail || (w_cnt_next == CNT_LAST)) begin
                            w_emit       = 1'b1;
                            w_state_next = S_IDLE;
                            // Last possible flit without a tail flag is
                            // still emitted, but flagged.
                            if (!w_tail) begin
                                w_err = 1'b1;
                            end
                            w_cnt_next = '0;
                        end
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    // Assembly buffer, flit count and latched VC
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf <= '0;
            r_cnt <= '0;
            r_vc  <= '0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            r_vc  <= w_vc_next;
        end
    end

    // Output register: loads on emit, clears on handshake otherwise, and
    // holds while stalled. The error pulse ignores output backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_vc_out <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_err;
            if (w_emit) begin
                r_valid  <= 1'b1;
                r_data   <= w_buf_next[IDL-1 -: WIDTH_DATA];
                r_vc_out <= w_vc_next;
            end else if (o_ready_in) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign i_ready_out = w_ready;
    assign o_valid_out = r_valid;
    assign o_data_out  = r_data;
    assign o_vc_out    = r_vc_out;
    assign o_error     = r_err;

endmodule

// File: tb/tb_depacketizer_n.sv
module tb_depacketizer_n;

    logic        clk;
    logic        rst_n;
    logic [17:0] i_flit_in;
    logic        i_valid_in;
    logic        i_ready_out;
    logic [11:0] o_data_out;
    logic [0:0]  o_vc_out;
    logic        o_valid_out;
    logic        o_ready_in;
    logic        o_error;

    int n_cmp;
    int n_fail;
    int err_seen;
    int err_exp;
    bit rand_bp;

    // Expected output words, {vc, data}, in emission order.
    logic [12:0] exp_q[$];

    depacketizer_n dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_flit_in   (i_flit_in),
        .i_valid_in  (i_valid_in),
        .i_ready_out (i_ready_out),
        .o_data_out  (o_data_out),
        .o_vc_out    (o_vc_out),
        .o_valid_out (o_valid_out),
        .o_ready_in  (o_ready_in),
        .o_error     (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: concatenate head payload and body payload MSB-first into the
    // 24-bit assembly, output is its top 12 bits.
    function automatic logic [12:0] model(input logic vc, input logic [9:0] hd,
                                          input logic [13:0] bd);
        logic [23:0] word;
        word = {hd, bd};
        return {vc, word[23:12]};
    endfunction

    function automatic logic [17:0] mk_head(input logic v, input logic t, input logic vc,
                                            input logic [3:0] addr, input logic [9:0] d);
        return {v, 1'b1, t, vc, addr, d};
    endfunction

    function automatic logic [17:0] mk_body(input logic v, input logic t, input logic vc,
                                            input logic [13:0] d);
        return {v, 1'b0, t, vc, d};
    endfunction

    // Called at posedge+2; returns at posedge+2 after the accepting edge.
    task automatic send(input logic [17:0] f);
        int n;
        i_flit_in  = f;
        i_valid_in = 1'b1;
        n = 0;
        @(negedge clk);
        while (!i_ready_out && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("send_ready_timeout", 32'(i_ready_out), 32'd1);
        @(posedge clk);
        #2;
        i_valid_in = 1'b0;
        i_flit_in  = '0;
    endtask

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    // Random output backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) o_ready_in = ($urandom_range(0, 3) != 0);
        end
    end

    // Output scoreboard and error-pulse counter.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_error) err_seen++;
            if (o_valid_out && o_ready_in) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected_valid", 32'(o_valid_out), 32'd0);
                end else begin
                    logic [12:0] e;
                    e = exp_q.pop_front();
                    check("out_data", 32'(o_data_out), 32'(e[11:0]));
                    check("out_vc", 32'(o_vc_out), 32'(e[12]));
                end
            end
        end
    end

    initial begin
        logic [9:0]  hd;
        logic [9:0]  hd2;
        logic [13:0] bd;
        logic [3:0]  addr;
        logic        vc;
        logic        vc2;
        int          kind;
        int          wait_n;

        n_cmp = 0; n_fail = 0; err_seen = 0; err_exp = 0;
        rand_bp = 1'b0;
        rst_n = 1'b0; i_flit_in = '0; i_valid_in = 1'b0; o_ready_in = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(o_valid_out), 32'd0);
        check("rst_data", 32'(o_data_out), 32'd0);
        check("rst_vc", 32'(o_vc_out), 32'd0);
        check("rst_error", 32'(o_error), 32'd0);
        check("rst_ready_out", 32'(i_ready_out), 32'd1);
        align();
        rst_n = 1'b1;
        align();

        // Basic two-flit packet
        send(mk_head(1'b1, 1'b0, 1'b1, 4'h5, 10'h3FF));
        exp_q.push_back(model(1'b1, 10'h3FF, 14'h0000));
        send(mk_body(1'b1, 1'b1, 1'b1, 14'h0000));
        @(negedge clk);
        check("t1_valid", 32'(o_valid_out), 32'd1);
        check("t1_data", 32'(o_data_out), 32'hFFC);
        check("t1_vc", 32'(o_vc_out), 32'd1);
        check("t1_error", 32'(o_error), 32'd0);
        align();

        // Same packet under 5 cycles of backpressure
        o_ready_in = 1'b0;
        send(mk_head(1'b1, 1'b0, 1'b1, 4'h5, 10'h3FF));
        exp_q.push_back(model(1'b1, 10'h3FF, 14'h0000));
        send(mk_body(1'b1, 1'b1, 1'b1, 14'h0000));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_hold_valid", 32'(o_valid_out), 32'd1);
            check("t2_hold_data", 32'(o_data_out), 32'hFFC);
            check("t2_hold_vc", 32'(o_vc_out), 32'd1);
            check("t2_ready_out", 32'(i_ready_out), 32'd0);
        end
        align();
        o_ready_in = 1'b1;
        @(negedge clk);
        check("t2_xfer_valid", 32'(o_valid_out), 32'd1);
        align();
        @(negedge clk);
        check("t2_drop_valid", 32'(o_valid_out), 32'd0);
        align();

        // Orphan body flit in IDLE
        send(mk_body(1'b1, 1'b0, 1'b0, 14'h1ABC));
        err_exp++;
        @(negedge clk);
        check("t3_error_pulse", 32'(o_error), 32'd1);
        check("t3_no_valid", 32'(o_valid_out), 32'd0);
        @(negedge clk);
        check("t3_error_clear", 32'(o_error), 32'd0);
        align();
        send(mk_head(1'b1, 1'b0, 1'b0, 4'h2, 10'h2C3));
        exp_q.push_back(model(1'b0, 10'h2C3, 14'h2A5A));
        send(mk_body(1'b1, 1'b1, 1'b0, 14'h2A5A));
        @(negedge clk);
        check("t3_next_valid", 32'(o_valid_out), 32'd1);
        align();

        // Head interrupts a partial packet
        send(mk_head(1'b1, 1'b0, 1'b0, 4'h1, 10'h2AA));
        send(mk_head(1'b1, 1'b0, 1'b1, 4'h3, 10'h155));
        err_exp++;
        @(negedge clk);
        check("t4_error_pulse", 32'(o_error), 32'd1);
        check("t4_no_valid", 32'(o_valid_out), 32'd0);
        align();
        exp_q.push_back(model(1'b1, 10'h155, 14'h3FFF));
        send(mk_body(1'b1, 1'b1, 1'b1, 14'h3FFF));
        @(negedge clk);
        check("t4_valid", 32'(o_valid_out), 32'd1);
        check("t4_data", 32'(o_data_out), 32'h557);
        check("t4_vc", 32'(o_vc_out), 32'd1);
        check("t4_error", 32'(o_error), 32'd0);
        align();

        // Single flit with head and tail set
        exp_q.push_back(model(1'b0, 10'h001, 14'h0000));
        send(mk_head(1'b1, 1'b1, 1'b0, 4'hF, 10'h001));
        @(negedge clk);
        check("t5_valid", 32'(o_valid_out), 32'd1);
        check("t5_data", 32'(o_data_out), 32'h004);
        check("t5_error", 32'(o_error), 32'd0);
        align();

        // Asynchronous reset drops a pending output
        o_ready_in = 1'b0;
        send(mk_head(1'b1, 1'b0, 1'b1, 4'h0, 10'h3C3));
        send(mk_body(1'b1, 1'b1, 1'b1, 14'h1234));
        @(negedge clk);
        check("t6_pending_valid", 32'(o_valid_out), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_valid", 32'(o_valid_out), 32'd0);
        check("t6_async_data", 32'(o_data_out), 32'd0);
        align();
        rst_n = 1'b1;
        o_ready_in = 1'b1;
        align();

        // Reset mid-packet: the following tail is an orphan
        send(mk_head(1'b1, 1'b0, 1'b0, 4'h7, 10'h0AA));
        #3;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        align();
        send(mk_body(1'b1, 1'b1, 1'b0, 14'h0F0F));
        err_exp++;
        @(negedge clk);
        check("t6_orphan_error", 32'(o_error), 32'd1);
        check("t6_orphan_no_valid", 32'(o_valid_out), 32'd0);
        @(negedge clk);
        check("t6_still_no_valid", 32'(o_valid_out), 32'd0);
        align();

        // Randomized traffic with backpressure
        rand_bp = 1'b1;
        for (int it = 0; it < 250; it++) begin
            kind = $urandom_range(0, 9);
            hd   = 10'($urandom);
            hd2  = 10'($urandom);
            bd   = 14'($urandom);
            addr = 4'($urandom);
            vc   = 1'($urandom);
            vc2  = 1'($urandom);
            if ($urandom_range(0, 4) == 0)
                send({1'b0, 17'($urandom)});
            case (kind)
                5: begin
                    exp_q.push_back(model(vc, hd, 14'h0));
                    send(mk_head(1'b1, 1'b1, vc, addr, hd));
                end
                6: begin
                    exp_q.push_back(model(vc, hd, bd));
                    err_exp++;
                    send(mk_head(1'b1, 1'b0, vc, addr, hd));
                    send(mk_body(1'b1, 1'b0, vc2, bd));
                end
                7: begin
                    err_exp++;
                    send(mk_body(1'b1, 1'($urandom), vc, bd));
                end
                8: begin
                    err_exp++;
                    exp_q.push_back(model(vc, hd, bd));
                    send(mk_head(1'b1, 1'b0, vc2, addr, hd2));
                    send(mk_head(1'b1, 1'b0, vc, addr, hd));
                    send(mk_body(1'b1, 1'b1, vc2, bd));
                end
                9: begin
                    exp_q.push_back(model(vc, hd, bd));
                    send(mk_head(1'b1, 1'b0, vc, addr, hd));
                    send({1'b0, 17'($urandom)});
                    send(mk_body(1'b1, 1'b1, vc2, bd));
                end
                default: begin
                    exp_q.push_back(model(vc, hd, bd));
                    send(mk_head(1'b1, 1'b0, vc, addr, hd));
                    send(mk_body(1'b1, 1'b1, vc2, bd));
                end
            endcase
        end
        rand_bp = 1'b0;
        o_ready_in = 1'b1;
        wait_n = 0;
        while (exp_q.size() != 0 && wait_n < 200) begin
            align();
            wait_n++;
        end
        repeat (3) align();
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("error_pulse_count", 32'(err_seen), 32'(err_exp));
        check("final_valid_low", 32'(o_valid_out), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
